// File: rtl/pmem_burst_responder.sv
// Line-oriented memory model: 256-bit lines moved as 4 x 64-bit beats after a fixed latency.
// Define PMEM_PROTOCOL_CHECK_EN to build the sticky protocol-violation flag on err.
module pmem_burst_responder #(
  parameter int LATENCY     = 8,
  parameter int DEPTH_LINES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic        pmem_resp,
  output logic [63:0] pmem_rdata,
  output logic        busy,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH_LINES);

  typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, DONE} state_t;

  state_t           state, state_n;
  logic [7:0]       cnt;
  logic [1:0]       beat;
  logic [IDX_W-1:0] idx_q;
  logic             cmd_rd_q;
  logic [63:0]      mem [DEPTH_LINES*4];

  logic             cmd_any;
  logic             cmd_live;
  logic [IDX_W-1:0] idx_in;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       rd_beat;
  logic             unused_addr;

  assign cmd_any     = pmem_read | pmem_write;
  assign cmd_live    = cmd_rd_q ? pmem_read : pmem_write;
  assign idx_in      = pmem_address[5 +: IDX_W];
  assign unused_addr = ^pmem_address;

  // The burst state is entered on the edge that ends cycle LATENCY-1, so the
  // counter leaves WAIT at 1; LATENCY=1 has to bypass WAIT entirely.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (cmd_any) begin
          if (LATENCY == 1) state_n = pmem_read ? RBURST : WBURST;
          else              state_n = WAIT;
        end
      end
      WAIT: begin
        if (!cmd_live)         state_n = IDLE;
        else if (cnt == 8'd1)  state_n = cmd_rd_q ? RBURST : WBURST;
      end
      RBURST, WBURST: begin
        if (beat == 2'd3) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 8'd0;
      beat <= 2'd0;
    end else begin
      if (state == IDLE && cmd_any) begin
        cnt      <= 8'(LATENCY - 1);
        idx_q    <= idx_in;
        cmd_rd_q <= pmem_read;
      end else if (state == WAIT) begin
        cnt <= cnt - 8'd1;
      end
      beat <= (state == RBURST || state == WBURST) ? beat + 2'd1 : 2'd0;
    end
  end

  // Read data is fetched one edge ahead so it is registered in its resp cycle.
  assign rd_idx  = (state == IDLE) ? idx_in : idx_q;
  assign rd_beat = (state == RBURST) ? beat + 2'd1 : 2'd0;

  always_ff @(posedge clk) begin
    if (rst)                    pmem_rdata <= 64'd0;
    else if (state_n == RBURST) pmem_rdata <= mem[{rd_idx, rd_beat}];
    else                        pmem_rdata <= 64'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst && state == WBURST) mem[{idx_q, beat}] <= pmem_wdata;
  end

  assign pmem_resp = (state == RBURST) || (state == WBURST);
  assign busy      = (state != IDLE);

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [26:0] line_q;
  logic        viol;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_any) line_q <= pmem_address[31:5];
  end

  always_comb begin
    viol = 1'b0;
    if (state == IDLE && pmem_read && pmem_write) viol = 1'b1;
    if (state == WAIT && !cmd_live)               viol = 1'b1;
    if ((state == WAIT || state == RBURST || state == WBURST) && cmd_any &&
        pmem_address[31:5] != line_q)             viol = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)       err_q <= 1'b0;
    else if (viol) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Bench for pmem_burst_responder: per-cycle comparison against a transaction-level
// model (cycle-indexed expectation tables plus a line memory), with literal pin checks.
module tb_pmem_burst_responder;

  localparam int L    = 8;
  localparam int MAXC = 8192;

`ifdef PMEM_PROTOCOL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pmem_read = 1'b0;
  logic        pmem_write = 1'b0;
  logic [31:0] pmem_address = 32'd0;
  logic [63:0] pmem_wdata = 64'd0;
  logic        pmem_resp;
  logic [63:0] pmem_rdata;
  logic        busy;
  logic        err;

  pmem_burst_responder #(.LATENCY(L), .DEPTH_LINES(256)) dut (
    .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  bit        exp_resp  [MAXC];
  bit        exp_busy  [MAXC];
  bit [63:0] exp_rdata [MAXC];
  bit        skip_rd   [MAXC];
  bit        viol      [MAXC];
  bit [63:0] mm        [1024];
  bit        err_m = 1'b0;

  typedef struct { int c; logic [63:0] d; } obs_t;
  obs_t obs_q[$];

  int pool[8] = '{0, 2, 8, 16, 5, 77, 200, 255};

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) err_m <= 1'b0;
    else if (cyc < MAXC && viol[cyc]) err_m <= 1'b1;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_on && cyc < MAXC) begin
      check(pmem_resp === exp_resp[cyc], $sformatf("resp@%0d", cyc),
            64'(pmem_resp), 64'(exp_resp[cyc]));
      check(busy === exp_busy[cyc], $sformatf("busy@%0d", cyc),
            64'(busy), 64'(exp_busy[cyc]));
      if (!skip_rd[cyc])
        check(pmem_rdata === exp_rdata[cyc], $sformatf("rdata@%0d", cyc),
              pmem_rdata, exp_rdata[cyc]);
      check(err === (CHK_EN & err_m), $sformatf("err@%0d", cyc),
            64'(err), 64'(CHK_EN & err_m));
      if (pmem_resp === 1'b1) obs_q.push_back('{c: cyc, d: pmem_rdata});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // kind: 0 read, 1 write, 2 read+write. Called in an IDLE cycle, returns in an IDLE cycle.
  task automatic txn(input int kind, input logic [31:0] addr, input logic [255:0] line,
                     input int drop_at, input int rst_at, input bit scramble, output int t0);
    int idx, last, end_off;
    bit rd, abort;
    rd  = (kind != 1);
    idx = int'(addr[12:5]);
    t0  = cyc;
    pmem_read    = rd;
    pmem_write   = (kind != 0);
    pmem_address = addr;
    pmem_wdata   = {$urandom, $urandom};
    if (kind == 2) viol[t0] = 1'b1;
    abort = (drop_at >= 1 && drop_at <= L - 1);
    if (abort) begin
      for (int o = 1; o <= drop_at; o++) exp_busy[t0 + o] = 1'b1;
      viol[t0 + drop_at] = 1'b1;
      end_off = drop_at + 1;
    end else begin
      last = (rst_at >= 0) ? rst_at : L + 4;
      for (int o = 1; o <= last; o++) exp_busy[t0 + o] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (rst_at < 0 || L + k <= rst_at) begin
          exp_resp[t0 + L + k] = 1'b1;
          if (rd) exp_rdata[t0 + L + k] = mm[idx*4 + k];
          else    skip_rd[t0 + L + k] = 1'b1;
        end
        if (!rd && (rst_at < 0 || L + k < rst_at)) mm[idx*4 + k] = line[64*k +: 64];
      end
      end_off = last + 1;
    end
    for (int o = 1; o < end_off; o++) begin
      next_cycle();
      if (o == drop_at) begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
      if (o == rst_at) rst = 1'b1;
      if (scramble && $urandom_range(3) == 0) pmem_address = $urandom;
      if (o >= L && o <= L + 3) pmem_wdata = line[64*(o - L) +: 64];
      else                      pmem_wdata = {$urandom, $urandom};
      if ((pmem_read || pmem_write) && o <= L + 3 && pmem_address[31:5] != addr[31:5])
        viol[t0 + o] = 1'b1;
    end
    next_cycle();
    rst        = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  task automatic pin(input string nm, input int t0, input logic [255:0] expl);
    check(obs_q.size() == 4, {nm, " beats"}, 64'(obs_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
      check(obs_q[k].c == t0 + 8 + k, $sformatf("%s cyc%0d", nm, k),
            64'(obs_q[k].c - t0), 64'(8 + k));
      check(obs_q[k].d === expl[64*k +: 64], $sformatf("%s data%0d", nm, k),
            obs_q[k].d, expl[64*k +: 64]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, kind, r, drop_at, rst_at;
    logic [31:0]  a;
    logic [255:0] ln;
    logic [255:0] l1 = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    logic [255:0] la = 256'hAAAA0003AAAA0003_AAAA0002AAAA0002_AAAA0001AAAA0001_AAAA0000AAAA0000;
    logic [255:0] lb = 256'hBBBB0003BBBB0003_BBBB0002BBBB0002_BBBB0001BBBB0001_BBBB0000BBBB0000;
    logic [255:0] lp = 256'h0D0D0D0D0D0D0D03_0C0C0C0C0C0C0C02_0B0B0B0B0B0B0B01_0A0A0A0A0A0A0A00;
    logic [255:0] lx;

    repeat (3) next_cycle();
    rst    = 1'b0;
    chk_on = 1'b1;
    check(pmem_resp === 1'b0, "reset resp", 64'(pmem_resp), 64'd0);
    check(busy === 1'b0, "reset busy", 64'(busy), 64'd0);
    check(pmem_rdata === 64'd0, "reset rdata", pmem_rdata, 64'd0);
    check(err === 1'b0, "reset err", 64'(err), 64'd0);

    foreach (pool[i]) txn(1, 32'(pool[i]) << 5, rand_line(), L + 4, -1, 1'b0, t0);

    txn(1, 32'h100, l1, L + 4, -1, 1'b0, t0);
    obs_q.delete();
    txn(0, 32'h100, '0, L + 4, -1, 1'b0, t0);
    pin("rd100", t0, l1);

    obs_q.delete();
    txn(0, 32'h11F, '0, L + 4, -1, 1'b0, t0);
    pin("rd11F", t0, l1);

    lx = rand_line();
    txn(1, 32'h0000_2000, lx, L + 4, -1, 1'b0, t0);
    obs_q.delete();
    txn(0, 32'h0, '0, L + 4, -1, 1'b0, t0);
    pin("alias", t0, lx);

    txn(1, 32'h40, lp, L + 4, -1, 1'b0, t0);
    obs_q.delete();
    txn(2, 32'h40, rand_line(), L + 4, -1, 1'b0, t0);
    pin("both", t0, lp);
    check(err === CHK_EN, "both err", 64'(err), 64'(CHK_EN));
    obs_q.delete();
    txn(0, 32'h40, '0, L + 4, -1, 1'b0, t0);
    pin("both_nowr", t0, lp);

    txn(1, 32'h200, la, L + 4, -1, 1'b0, t0);
    txn(1, 32'h200, lb, L + 4, L + 2, 1'b0, t0);
    check(pmem_resp === 1'b0, "rst resp", 64'(pmem_resp), 64'd0);
    check(busy === 1'b0, "rst busy", 64'(busy), 64'd0);
    obs_q.delete();
    txn(0, 32'h200, '0, L + 4, -1, 1'b0, t0);
    pin("rst_mix", t0, {la[255:128], lb[127:0]});

    obs_q.delete();
    txn(0, 32'h100, '0, 3, -1, 1'b0, t0);
    check(cyc - t0 == 4, "abort ret", 64'(cyc - t0), 64'd4);
    check(busy === 1'b0, "abort busy", 64'(busy), 64'd0);
    check(obs_q.size() == 0, "abort noresp", 64'(obs_q.size()), 64'd0);
    txn(0, 32'h100, '0, L + 4, -1, 1'b0, t0);
    pin("after_abort", t0, l1);

    for (int n = 0; n < 80; n++) begin
      r    = int'($urandom_range(9));
      kind = (r < 4) ? 0 : (r < 8) ? 1 : 2;
      a    = $urandom;
      a[12:5] = 8'(pool[$urandom_range(7)]);
      r = int'($urandom_range(9));
      drop_at = (r == 0) ? int'($urandom_range(1, L - 1)) :
                (r == 1) ? L + int'($urandom_range(3)) : L + 4;
      rst_at  = (r != 0 && $urandom_range(9) == 0) ? L + int'($urandom_range(3)) : -1;
      txn(kind, a, rand_line(), drop_at, rst_at, 1'($urandom_range(1)), t0);
      repeat ($urandom_range(2)) next_cycle();
    end
    repeat (3) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_burst_responder.md
PMEM_BURST_RESPONDER -- requirements
Module: pmem_burst_responder

Interface
REQ-001 Parameter LATENCY, default 8: cycles from command acceptance to first response beat; legal range 1..255.
REQ-002 Parameter DEPTH_LINES, default 256: number of 256-bit lines stored; power of two.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pmem_read  input  1  line read request, held by the initiator until the final response beat.
REQ-006 pmem_write  input  1  line write request, held by the initiator until the final response beat.
REQ-007 pmem_address  input  32  line address; bits [4:0] ignored.
REQ-008 pmem_wdata  input  64  write beat data, sampled when pmem_resp=1 during a write.
REQ-009 pmem_resp  output  1  beat strobe, high for exactly 4 consecutive cycles per transaction.
REQ-010 pmem_rdata  output  64  read beat data, valid when pmem_resp=1 during a read.
REQ-011 busy  output  1  high in every state other than IDLE.
REQ-012 err  output  1  sticky protocol-violation flag (see Configuration).

Function
REQ-013 Storage: DEPTH_LINES x 4 beats x 64 bits; line index = pmem_address[5+log2(DEPTH_LINES)-1:5]; higher address bits ignored (aliasing wraps).
REQ-014 Beat order: beat 0 = bits [63:0] of the line, ascending to beat 3 = bits [255:192].
REQ-015 States: IDLE, WAIT, RBURST, WBURST, DONE.
REQ-016 IDLE -> WAIT when pmem_read or pmem_write is high; latch address and command; load latency counter with LATENCY-1.
REQ-017 Both pmem_read and pmem_write high in IDLE: read wins.
REQ-018 WAIT: decrement counter each cycle; at 0, go to RBURST or WBURST per the latched command.
REQ-019 Timing: if the command is first seen in IDLE at cycle 0, pmem_resp is high in cycles LATENCY..LATENCY+3 and low otherwise.
REQ-020 RBURST: pmem_rdata = stored beat k in the k-th resp cycle, registered output; pmem_rdata is 0 whenever pmem_resp=0.
REQ-021 WBURST: pmem_wdata is written to beat k on the k-th resp edge; each beat commits independently.
REQ-022 After beat 3 -> DONE for exactly one cycle (resp=0), then IDLE; a command still high in DONE is not accepted until IDLE.
REQ-023 Back-to-back: minimum gap of one DONE cycle plus one IDLE cycle between transactions.
REQ-024 Command deasserted during WAIT: abort to IDLE next cycle, no resp, no memory change.
REQ-025 Command deasserted during RBURST/WBURST: burst completes all 4 beats regardless; beats use the latched address.
REQ-026 Address change during WAIT or a burst is ignored; the latched address governs.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, counter=0, pmem_resp=0, pmem_rdata=0, busy=0, err=0.
REQ-028 Storage contents are not reset; beats written before a mid-burst reset remain; the remaining beats are discarded.
REQ-029 rst has priority over every other event in the same cycle.

Configuration
REQ-030 Macro PMEM_PROTOCOL_CHECK_EN defined: err sets and holds until rst on: read&write both high in IDLE; command deassert in WAIT; pmem_address[31:5] differing from the latched value while busy and command high.
REQ-031 Macro undefined: err is constant 0 and no check logic is generated; all other behaviour is identical.

Verification
REQ-032 LATENCY=8: write line 0x100 with beats 0x11..,0x22..,0x33..,0x44.. (64-bit patterns), then read 0x100 -> resp in cycles 8..11 after acceptance; rdata returns the same 4 beats in order.
REQ-033 Read 0x100+0x1F (unaligned low bits) -> identical data to the 0x100 read.
REQ-034 DEPTH_LINES=256: write 0x0000_2000 (aliases index 0), read 0x0 -> written data returned.
REQ-035 Read and write both high at 0x40 -> read performed, no memory change; err=1 with the macro defined, err=0 without it.
REQ-036 Reset asserted after write beat 1 of line 0x200 -> next cycle resp=0, busy=0; a later read of 0x200 returns the new beats 0-1 and the old beats 2-3.
REQ-037 Read deasserted at cycle 3 of WAIT -> no resp ever, busy=0 from cycle 4, next command accepted in IDLE with full LATENCY.
